// File: rtl/wb2core.sv
// wb2core: Wishbone pipelined slave to core-style request/grant initiator bridge.
// Ports: clk, rst (async, active-high); Wishbone slave wb_cyc/wb_stb/wb_we/wb_adr[27:0]/
//   wb_sel[3:0]/wb_dat_m[31:0] in, wb_stall/wb_ack/wb_err/wb_dat_s[31:0] out;
//   core initiator core_req/core_we/core_addr[31:0]/core_be[3:0]/core_wdata[31:0] out,
//   core_gnt/core_rvalid/core_err/core_rdata[31:0] in.
// DEPTH (1..4) bounds accepted-but-unanswered transactions.
// Define WB2CORE_ERR_EN to map core_err onto wb_err; otherwise every response is an ack.
module wb2core #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [27:0] wb_adr,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_m,
    output logic        wb_stall,
    output logic        wb_ack,
    output logic        wb_err,
    output logic [31:0] wb_dat_s,
    output logic        core_req,
    output logic        core_we,
    output logic [31:0] core_addr,
    output logic [3:0]  core_be,
    output logic [31:0] core_wdata,
    input  logic        core_gnt,
    input  logic        core_rvalid,
    input  logic        core_err,
    input  logic [31:0] core_rdata
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    localparam logic [2:0] DMAX = 3'(DEPTH);
    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       accept, take, resp, is_err, ack_q, err_q;

    assign wb_stall   = ~core_gnt | (cnt == DMAX) | (state == DRAIN);
    assign core_req   = wb_cyc & wb_stb & (cnt < DMAX) & (state != DRAIN);
    assign core_addr  = {2'b00, wb_adr, 2'b00};
    assign core_we    = wb_we;
    assign core_be    = wb_sel;
    assign core_wdata = wb_dat_m;
    assign accept     = wb_cyc & wb_stb & ~wb_stall;
    // responses with nothing outstanding are spurious and dropped
    assign take       = core_rvalid & (cnt != 3'd0);
    assign resp       = take & (state == ACTIVE) & wb_cyc;
`ifdef WB2CORE_ERR_EN
    assign is_err     = core_err;
`else
    assign is_err     = core_err & 1'b0;
`endif
    // a registered response is withheld if the master has dropped the cycle meanwhile
    assign wb_ack     = ack_q & wb_cyc;
    assign wb_err     = err_q & wb_cyc;

    always_comb begin
        cnt_nxt   = cnt + {2'b00, accept} - {2'b00, take};
        state_nxt = state;
        state_nxt = (state == IDLE)   ? (accept ? ACTIVE : IDLE) :
                    (state == ACTIVE) ? ((cnt_nxt == 3'd0) ? IDLE : (wb_cyc ? ACTIVE : DRAIN)) :
                                        ((cnt_nxt == 3'd0) ? IDLE : DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            wb_dat_s <= 32'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ack_q    <= resp & ~is_err;
            err_q    <= resp & is_err;
            if (resp) wb_dat_s <= core_rdata;
        end
    end
endmodule

// File: tb/tb_wb2core.sv
// tb_wb2core: randomized scoreboard bench for wb2core against a transaction-level model.
module tb_wb2core;
    localparam int DEPTH = 2;
`ifdef WB2CORE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } resp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        wb_cyc = 0, wb_stb = 0, wb_we = 0;
    logic [27:0] wb_adr = 0;
    logic [3:0]  wb_sel = 0;
    logic [31:0] wb_dat_m = 0;
    logic        wb_stall, wb_ack, wb_err;
    logic [31:0] wb_dat_s;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic [3:0]  core_be;
    logic        core_gnt = 0, core_rvalid = 0, core_err = 0;
    logic [31:0] core_rdata = 0;

    int checks = 0, failures = 0;
    resp_t q[$];
    resp_t pend;
    bit    pend_v = 0;
    int    outstanding = 0;
    bit    aborted = 0;

    wb2core #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_dat_m(wb_dat_m),
        .wb_stall(wb_stall), .wb_ack(wb_ack), .wb_err(wb_err), .wb_dat_s(wb_dat_s),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_be(core_be),
        .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_err(core_err),
        .core_rdata(core_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle either a queued response must appear or nothing must.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (q.size() > 0) begin
                resp_t e;
                e = q.pop_front();
                chk("resp_ack", {31'd0, wb_ack}, {31'd0, e.ack});
                chk("resp_err", {31'd0, wb_err}, {31'd0, e.err});
                chk("resp_dat", wb_dat_s, e.dat);
            end else if (wb_ack || wb_err) begin
                chk("spurious_resp", {30'd0, wb_ack, wb_err}, 32'd0);
            end
        end
    end

    function automatic void model_reset();
        outstanding = 0;
        aborted = 0;
        pend_v = 0;
        q.delete();
    endfunction

    task automatic cycle(input logic c, s, w, input logic [27:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic g, rv, e, input logic [31:0] rd);
        bit exp_stall, exp_req, acc, took;
        @(negedge clk);
        wb_cyc = c; wb_stb = s; wb_we = w; wb_adr = a; wb_sel = b; wb_dat_m = d;
        core_gnt = g; core_rvalid = rv; core_err = e; core_rdata = rd;
        if (pend_v && c) q.push_back(pend);
        pend_v = 0;
        exp_stall = !g || outstanding == DEPTH || aborted;
        exp_req   = c && s && outstanding < DEPTH && !aborted;
        #1;
        chk("stall", {31'd0, wb_stall}, {31'd0, exp_stall});
        chk("req", {31'd0, core_req}, {31'd0, exp_req});
        if (s) begin
            chk("addr", core_addr, 32'(a) * 4);
            chk("fwd", {core_wdata[27:0], core_be, 3'd0, core_we}, {d[27:0], b, 3'd0, w});
        end
        acc  = c && s && !exp_stall;
        took = rv && outstanding > 0;
        if (took && !aborted && c) begin
            pend.err = e && ERR_EN;
            pend.ack = !pend.err;
            pend.dat = rd;
            pend_v = 1;
        end
        outstanding = outstanding + int'(acc) - int'(took);
        aborted = aborted ? (outstanding != 0) : (!c && outstanding > 0);
    endtask

    task automatic idle(input logic c, input logic rv, input logic [31:0] rd);
        cycle(c, 0, 0, 28'd0, 4'd0, 32'd0, 1, rv, 0, rd);
    endtask

    initial begin
        #1;
        chk("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_err", {31'd0, wb_err}, 32'd0);
        chk("rst_dat", wb_dat_s, 32'd0);
        @(negedge clk);
        rst = 0;
        // single read
        cycle(1, 1, 0, 28'h0000100, 4'hF, 32'd0, 1, 0, 0, 32'd0);
        idle(1, 1, 32'hDEADBEEF);
        idle(1, 0, 32'd0);
        // back-to-back until stall, then release
        cycle(1, 1, 1, 28'h1, 4'h1, 32'h11, 1, 0, 0, 32'd0);
        cycle(1, 1, 1, 28'h2, 4'h3, 32'h22, 1, 0, 0, 32'd0);
        cycle(1, 1, 1, 28'h3, 4'h7, 32'h33, 1, 0, 0, 32'd0);
        cycle(1, 1, 1, 28'h3, 4'h7, 32'h33, 1, 1, 0, 32'hA1);
        cycle(1, 1, 1, 28'h3, 4'h7, 32'h33, 1, 0, 0, 32'd0);
        idle(1, 1, 32'hA2);
        idle(1, 1, 32'hA3);
        idle(1, 0, 32'd0);
        // grant withheld for three cycles
        repeat (3) cycle(1, 1, 0, 28'h44, 4'hF, 32'd0, 0, 0, 0, 32'd0);
        cycle(1, 1, 0, 28'h44, 4'hF, 32'd0, 1, 0, 0, 32'd0);
        idle(1, 1, 32'h44);
        // error response
        cycle(1, 1, 0, 28'h55, 4'hF, 32'd0, 1, 0, 0, 32'd0);
        cycle(1, 0, 0, 28'h0, 4'h0, 32'd0, 1, 1, 1, 32'hE0E0);
        idle(1, 0, 32'd0);
        // abort with two outstanding
        cycle(1, 1, 0, 28'h66, 4'hF, 32'd0, 1, 0, 0, 32'd0);
        cycle(1, 1, 0, 28'h67, 4'hF, 32'd0, 1, 0, 0, 32'd0);
        idle(0, 0, 32'd0);
        cycle(1, 1, 0, 28'h68, 4'hF, 32'd0, 1, 1, 0, 32'hB1);
        idle(0, 1, 32'hB2);
        cycle(1, 1, 0, 28'h69, 4'hF, 32'd0, 1, 0, 0, 32'd0);
        idle(1, 1, 32'hB3);
        // async reset while a response is presented and one remains outstanding
        cycle(1, 1, 0, 28'h70, 4'hF, 32'd0, 1, 0, 0, 32'd0);
        cycle(1, 1, 0, 28'h71, 4'hF, 32'd0, 1, 0, 0, 32'd0);
        idle(1, 1, 32'hC1);
        idle(1, 0, 32'd0);
        #2;
        rst = 1;
        #1;
        chk("arst_ack", {31'd0, wb_ack}, 32'd0);
        chk("arst_err", {31'd0, wb_err}, 32'd0);
        chk("arst_dat", wb_dat_s, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        idle(1, 1, 32'hC2);
        idle(1, 0, 32'd0);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 28'($urandom),
                  4'($urandom), $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom);
        for (int i = 0; i < 8; i++) idle(1, 1, 32'(i));
        idle(1, 0, 32'd0);
        idle(1, 0, 32'd0);
        chk("leftover", 32'(q.size()) + 32'(pend_v), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
